// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot gate scheduler: state and direction
// encodings, default timing, and the timer width helper.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CAR = 2'd1,
        PASSING  = 2'd2,
        HOLD     = 2'd3
    } gate_state_e;

    typedef enum logic {
        DIR_ENTRY = 1'b0,
        DIR_EXIT  = 1'b1
    } gate_dir_e;

    localparam int DEF_CAPACITY       = 8;
    localparam int DEF_CNT_W          = 4;
    localparam int DEF_HOLD_CYCLES    = 50;
    localparam int DEF_TIMEOUT_CYCLES = 500;

    // The timer is loaded with (cycles - 1), so it must hold max(a, b) - 1.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter shared by the car-arrival timeout and the hold period;
// done is high while the count sits at zero.
module gate_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/gate_scheduler.sv
// Round-robin scheduler sharing one barrier gate between entry and exit lanes.
// Optional GATE_STATS_EN adds entry/exit totals and a timeout counter.
module gate_scheduler
    import parking_pkg::*;
#(
    parameter int CAPACITY       = DEF_CAPACITY,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_sense,
    output logic             gate_open,
    output logic             busy,
    output logic             grant_entry,
    output logic             grant_exit,
    output logic             deny,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
`ifdef GATE_STATS_EN
    ,
    output logic [15:0]      total_entries,
    output logic [15:0]      total_exits,
    output logic [7:0]       timeouts
`endif
);

    localparam int TW = timer_width(TIMEOUT_CYCLES, HOLD_CYCLES);
    localparam logic [TW-1:0]    TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]    HOLD_LOAD    = TW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP          = CNT_W'(CAPACITY);

    gate_state_e      state_q, state_d;
    gate_dir_e        last_dir_q, last_dir_d;
    logic             entry_pend_q, entry_pend_d;
    logic             exit_pend_q, exit_pend_d;
    logic             committed_q, committed_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             full_s, empty_s, pick_exit_s;
    logic             take_entry_s, take_exit_s;
    logic             grant_entry_s, grant_exit_s, deny_s;
    logic             tmr_load_s, tmr_done_s;
    logic [TW-1:0]    tmr_val_s;

    assign full_s  = (count_q == CAP);
    assign empty_s = (count_q == {CNT_W{1'b0}});

    gate_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .done     (tmr_done_s)
    );

    // Arbitration, gate sequencing and occupancy commit.
    always_comb begin
        state_d       = state_q;
        last_dir_d    = last_dir_q;
        count_d       = count_q;
        committed_d   = committed_q;
        pick_exit_s   = 1'b0;
        take_entry_s  = 1'b0;
        take_exit_s   = 1'b0;
        grant_entry_s = 1'b0;
        grant_exit_s  = 1'b0;
        deny_s        = 1'b0;
        tmr_load_s    = 1'b0;
        tmr_val_s     = TIMEOUT_LOAD;
        case (state_q)
            IDLE: begin
                if (entry_pend_q || exit_pend_q) begin
                    if (entry_pend_q && exit_pend_q) begin
                        pick_exit_s = (last_dir_q == DIR_ENTRY);
                    end else begin
                        pick_exit_s = exit_pend_q;
                    end
                    if (pick_exit_s) begin
                        grant_exit_s = 1'b1;
                        take_exit_s  = 1'b1;
                        last_dir_d   = DIR_EXIT;
                        committed_d  = 1'b0;
                        tmr_load_s   = 1'b1;
                        state_d      = WAIT_CAR;
                    end else if (full_s) begin
                        // Refused entry keeps last_dir so a waiting exit goes next.
                        deny_s       = 1'b1;
                        take_entry_s = 1'b1;
                    end else begin
                        grant_entry_s = 1'b1;
                        take_entry_s  = 1'b1;
                        last_dir_d    = DIR_ENTRY;
                        committed_d   = 1'b0;
                        tmr_load_s    = 1'b1;
                        state_d       = WAIT_CAR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_CAR: begin
                if (car_sense) begin
                    state_d = PASSING;
                end else if (tmr_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_CAR;
                end
            end
            PASSING: begin
                if (!car_sense) begin
                    // Only the first fall of a service commits; a rocking car does not.
                    if (!committed_q) begin
                        if (last_dir_q == DIR_ENTRY) begin
                            count_d = full_s ? count_q : count_q + CNT_W'(1);
                        end else begin
                            count_d = empty_s ? count_q : count_q - CNT_W'(1);
                        end
                    end else begin
                        count_d = count_q;
                    end
                    committed_d = 1'b1;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = HOLD_LOAD;
                    state_d     = HOLD;
                end else begin
                    state_d = PASSING;
                end
            end
            HOLD: begin
                if (car_sense) begin
                    state_d = PASSING;
                end else if (tmr_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A pulse coinciding with its own grant merges into that grant.
        entry_pend_d = take_entry_s ? 1'b0 : (entry_pend_q | entry_req);
        exit_pend_d  = take_exit_s  ? 1'b0 : (exit_pend_q | (exit_req & ~empty_s));
    end

    // Scheduler state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_dir_q   <= DIR_ENTRY;
            entry_pend_q <= 1'b0;
            exit_pend_q  <= 1'b0;
            committed_q  <= 1'b0;
            count_q      <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_dir_q   <= last_dir_d;
            entry_pend_q <= entry_pend_d;
            exit_pend_q  <= exit_pend_d;
            committed_q  <= committed_d;
            count_q      <= count_d;
        end
    end

    assign gate_open   = (state_q != IDLE);
    assign busy        = (state_q != IDLE);
    assign grant_entry = grant_entry_s;
    assign grant_exit  = grant_exit_s;
    assign deny        = deny_s;
    assign count       = count_q;
    assign full        = full_s;
    assign empty       = empty_s;

`ifdef GATE_STATS_EN
    logic [15:0] total_entries_q, total_entries_d;
    logic [15:0] total_exits_q, total_exits_d;
    logic [7:0]  timeouts_q, timeouts_d;
    logic        commit_s, abort_s;

    // Statistics follow the same commit and abort conditions as the sequencer.
    always_comb begin
        commit_s        = (state_q == PASSING) && !car_sense && !committed_q;
        abort_s         = (state_q == WAIT_CAR) && !car_sense && tmr_done_s;
        total_entries_d = total_entries_q;
        total_exits_d   = total_exits_q;
        timeouts_d      = timeouts_q;
        if (commit_s && (last_dir_q == DIR_ENTRY)) begin
            total_entries_d = total_entries_q + 16'd1;
        end else if (commit_s) begin
            total_exits_d = total_exits_q + 16'd1;
        end else begin
            total_entries_d = total_entries_q;
        end
        if (abort_s) begin
            timeouts_d = timeouts_q + 8'd1;
        end else begin
            timeouts_d = timeouts_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_entries_q <= 16'd0;
            total_exits_q   <= 16'd0;
            timeouts_q      <= 8'd0;
        end else begin
            total_entries_q <= total_entries_d;
            total_exits_q   <= total_exits_d;
            timeouts_q      <= timeouts_d;
        end
    end

    assign total_entries = total_entries_q;
    assign total_exits   = total_exits_q;
    assign timeouts      = timeouts_q;
`endif

endmodule

// File: tb/tb_gate_scheduler.sv
// Scoreboard bench for gate_scheduler: a lane-level model predicts grant/deny
// events and occupancy; a monitor compares each DUT event against the queue.
module tb_gate_scheduler;

    localparam int CAP  = 8;
    localparam int CW   = 4;
    localparam int HOLD = 12;
    localparam int TMO  = 40;

    logic          clk = 1'b0;
    logic          reset, entry_req, exit_req, car_sense;
    logic          gate_open, busy, grant_entry, grant_exit, deny, full, empty;
    logic [CW-1:0] count;
`ifdef GATE_STATS_EN
    logic [15:0]   total_entries, total_exits;
    logic [7:0]    timeouts;
`endif

    always #5 clk = ~clk;

    gate_scheduler #(
        .CAPACITY(CAP), .CNT_W(CW), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
        .car_sense(car_sense), .gate_open(gate_open), .busy(busy),
        .grant_entry(grant_entry), .grant_exit(grant_exit), .deny(deny),
        .count(count), .full(full), .empty(empty)
`ifdef GATE_STATS_EN
        , .total_entries(total_entries), .total_exits(total_exits), .timeouts(timeouts)
`endif
    );

    typedef struct {
        logic [2:0] kind;   // {grant_entry, grant_exit, deny}
        int         cnt;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    // Reference model: pending lanes, last winner, occupancy, statistics.
    int  m_count = 0;
    bit  m_pe = 1'b0, m_px = 1'b0, m_last_exit = 1'b0;
    int  m_entries = 0, m_exits = 0, m_tmo = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every grant/deny pulse must match the next predicted event.
    always @(negedge clk) begin
        ev_t ev;
        #1;
        if (reset === 1'b0 && (grant_entry | grant_exit | deny)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {29'd0, grant_entry, grant_exit, deny}, 32'd0);
            end else begin
                ev = exp_q.pop_front();
                check("event_kind", {29'd0, grant_entry, grant_exit, deny}, {29'd0, ev.kind});
                check("event_count", {28'd0, count}, ev.cnt);
            end
        end
    end

    task automatic pulse(input bit e, input bit x);
        entry_req = e;
        exit_req  = x;
        if (e) m_pe = 1'b1;
        if (x && m_count != 0) m_px = 1'b1;
        @(negedge clk);
        entry_req = 1'b0;
        exit_req  = 1'b0;
    endtask

    task automatic commit_model();
        if (m_last_exit) begin
            if (m_count > 0) m_count--;
            m_exits++;
        end else begin
            if (m_count < CAP) m_count++;
            m_entries++;
        end
    endtask

    task automatic wait_event(output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        while (waited < 20) begin
            if (grant_entry | grant_exit | deny) begin
                ok = 1'b1;
                return;
            end
            waited++;
            @(negedge clk);
        end
        check("event_wait", {31'd0, grant_entry | grant_exit | deny}, 32'd1);
    endtask

    task automatic count_open(input int limit, output int n);
        n = 0;
        while (gate_open === 1'b1 && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Drive one granted service: 0 normal pass, 1 no car (timeout), 2 rocking car.
    task automatic service(input int act);
        int n;
        int k;
        @(negedge clk);
        if (act == 1) begin
            count_open(TMO + 20, n);
            check("timeout_open_cycles", n, TMO);
            check("timeout_count", {28'd0, count}, m_count);
            m_tmo++;
        end else begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            car_sense = 1'b1;
            if ($urandom_range(0, 2) == 0) pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 3)) @(negedge clk);
            car_sense = 1'b0;
            commit_model();
            @(negedge clk);
            check("count_commit", {28'd0, count}, m_count);
            if (act == 2) begin
                k = $urandom_range(0, HOLD - 4);
                repeat (k) @(negedge clk);
                check("rock_gate_open", {31'd0, gate_open}, 32'd1);
                car_sense = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                car_sense = 1'b0;
                @(negedge clk);
                check("rock_single_commit", {28'd0, count}, m_count);
            end
            count_open(HOLD + 20, n);
            check("hold_open_cycles", n, HOLD);
        end
        check("busy_after_service", {31'd0, busy}, 32'd0);
    endtask

    // Issue request pulses, then serve everything the model says is pending.
    task automatic run_batch(input bit e, input bit x, input int act);
        bit ok;
        bit wx;
        bit first;
        int w;
        pulse(e, x);
        first = 1'b1;
        while (m_pe || m_px) begin
            wx = (m_pe && m_px) ? !m_last_exit : m_px;
            if (!wx && m_count == CAP) begin
                exp_q.push_back('{kind: 3'b001, cnt: m_count});
                m_pe = 1'b0;
            end else begin
                exp_q.push_back('{kind: (wx ? 3'b010 : 3'b100), cnt: m_count});
                if (wx) m_px = 1'b0;
                else    m_pe = 1'b0;
                m_last_exit = wx;
            end
            wait_event(ok, w);
            if (!ok) break;
            if (first) check("first_event_latency", w, 0);
            first = 1'b0;
            if (deny) begin
                check("deny_gate_closed", {31'd0, gate_open}, 32'd0);
                @(negedge clk);
            end else begin
                service((act < 0) ? $urandom_range(0, 2) : act);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int w;
        bit e;
        bit x;
        int r;
        reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; car_sense = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_count", {28'd0, count}, 32'd0);
        check("reset_gate", {31'd0, gate_open}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_pulses", {29'd0, grant_entry, grant_exit, deny}, 32'd0);
        check("reset_empty_full", {30'd0, empty, full}, 32'd2);
        reset = 1'b0;
        @(negedge clk);

        run_batch(1'b1, 1'b0, 0);
        run_batch(1'b1, 1'b0, 0);
        run_batch(1'b1, 1'b1, 0);      // tie after entries: exit first, then entry
        run_batch(1'b1, 1'b0, 2);      // rocking car
        run_batch(1'b1, 1'b0, 1);      // no car arrives
        while (m_count < CAP) run_batch(1'b1, 1'b0, 0);
        check("full_flag", {31'd0, full}, 32'd1);
        run_batch(1'b1, 1'b0, 0);      // refused while full
        run_batch(1'b0, 1'b1, 1);      // exit aborts: last_dir = exit, still full
        run_batch(1'b1, 1'b1, 0);      // entry wins tie, denied, exit served next

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 7);
            e = (r % 2 == 0) || (r > 5);
            x = (r >= 3);
            if (!e && !x) e = 1'b1;
            run_batch(e, x, -1);
        end

        run_batch(1'b1, 1'b0, 0);
`ifdef GATE_STATS_EN
        check("stat_entries", {16'd0, total_entries}, m_entries & 32'hFFFF);
        check("stat_exits", {16'd0, total_exits}, m_exits & 32'hFFFF);
        check("stat_timeouts", {24'd0, timeouts}, m_tmo & 32'hFF);
`endif
        // Reset during PASSING with an exit pending.
        pulse(1'b0, 1'b1);
        exp_q.push_back('{kind: 3'b010, cnt: m_count});
        m_px = 1'b0;
        m_last_exit = 1'b1;
        wait_event(ok, w);
        @(negedge clk);
        car_sense = 1'b1;
        repeat (2) @(negedge clk);
        pulse(1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("midreset_gate", {31'd0, gate_open}, 32'd0);
        check("midreset_count", {28'd0, count}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        m_count = 0; m_pe = 1'b0; m_px = 1'b0; m_last_exit = 1'b0;
        m_entries = 0; m_exits = 0; m_tmo = 0;
        exp_q.delete();
        car_sense = 1'b0;
        @(negedge clk);
`ifdef GATE_STATS_EN
        check("stat_reset", {8'd0, total_entries[7:0], total_exits[7:0], timeouts}, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        pulse(1'b0, 1'b1);             // exit while empty is dropped
        for (int i = 0; i < 6; i++) begin
            check("dropped_exit_no_grant", {31'd0, grant_exit}, 32'd0);
            check("dropped_exit_idle", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        run_batch(1'b1, 1'b0, 0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gate_scheduler.md
Name: gate_scheduler

Overview:
- Shares a single barrier gate between the entry and exit lanes of the parking lot.
- Consumes one-cycle pulses from the per-button debouncers and latches them as pending requests.
- Grants them round-robin and sequences the gate through open, vehicle passage and hold.
- Maintains the occupancy count, committing each change only after a car has physically passed.

Parameters:
CAPACITY, 8, number of parking slots; full when count == CAPACITY
CNT_W, 4, width of count; must satisfy 2**CNT_W > CAPACITY
HOLD_CYCLES, 50, cycles gate stays open after car clears the sensor
TIMEOUT_CYCLES, 500, cycles to wait for a car after grant before aborting

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
entry_req  input  1  one-cycle pulse, entry button (debounced)
exit_req  input  1  one-cycle pulse, exit button (debounced)
car_sense  input  1  gate sensor level, high while a vehicle is under the barrier
gate_open  output  1  barrier drive, 1 = open
busy  output  1  1 in any state other than IDLE
grant_entry  output  1  one-cycle pulse when an entry is granted
grant_exit  output  1  one-cycle pulse when an exit is granted
deny  output  1  one-cycle pulse when an entry is refused because the lot is full
count  output  CNT_W  current occupancy
full  output  1  count == CAPACITY (combinational from count)
empty  output  1  count == 0 (combinational from count)

Behaviour:
Reset:
- Async reset forces state IDLE, count 0, both pending latches 0, last_dir = ENTRY, timer 0.
- All pulse outputs are 0 and gate_open is 0.
Request latching:
- entry_req sets entry_pend; exit_req sets exit_pend.
- A pulse arriving while its latch is already set is merged (no queueing beyond one per lane).
- exit_req while empty is dropped.
Arbitration in IDLE, when any latch is set:
- If both latches are set, grant the direction opposite last_dir (round-robin). After reset, exit wins the first tie.
- Entry granted while full: the entry latch clears, deny pulses for one cycle, and state stays IDLE. last_dir is unchanged, so a pending exit is served next cycle.
- Otherwise: the grant_* pulse fires, the latch clears, last_dir updates, and the block moves to WAIT_CAR.
States (gate_open = 1 in WAIT_CAR, PASSING and HOLD; 0 in IDLE):
- IDLE: see arbitration above.
- WAIT_CAR: timer loads TIMEOUT_CYCLES.
  - car_sense high -> PASSING.
  - Timer expiry -> IDLE with no count change (abort).
- PASSING: waits for car_sense low.
  - On the falling transition, commit: entry = count+1, exit = count-1. count updates in the cycle the block leaves PASSING.
  - Then -> HOLD.
- HOLD: counts HOLD_CYCLES cycles.
  - car_sense high again -> PASSING without a second commit (same vehicle rocking); the hold timer restarts on the next fall.
  - Timer expiry -> IDLE.
Requests during service:
- Requests arriving in any non-IDLE state still latch and are served after the return to IDLE.
- A request pulse in the same cycle as its own grant is merged into that grant.
Count limits:
- count saturates at CAPACITY and at 0 as a safety net; in-spec operation never reaches saturation.
Latency:
- Request pulse at cycle N -> grant pulse at N+1 at the earliest (latch, then arbitrate).

Optional Feature:
GATE_STATS_EN:
- Defined: adds outputs total_entries[15:0], total_exits[15:0] and timeouts[7:0].
  - The totals increment on commit; timeouts increments on a WAIT_CAR abort.
  - All three wrap modulo their width and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package parking_pkg:
  - State encoding constants IDLE/WAIT_CAR/PASSING/HOLD.
  - Direction constants DIR_ENTRY/DIR_EXIT.
  - Default timing constants.
- One sub-module, gate_timer: loadable down-counter with a done flag, used for both the timeout and the hold. Its width is derived from the larger of TIMEOUT_CYCLES and HOLD_CYCLES.

Test Plan:
- Single entry, empty lot:
  - Stimulus: entry_req pulse, car_sense high 3 cycles then low.
  - Required: grant_entry one cycle after the request; gate_open high through HOLD_CYCLES after the fall; count 0 -> 1; busy drops at the end.
- Round-robin tie:
  - Stimulus: count=2, entry_req and exit_req in the same cycle right after reset.
  - Required: exit granted first (count 2 -> 1), then entry (count -> 2); grant pulses in that order.
- Full lot:
  - Stimulus: fill the lot to CAPACITY=8, then entry_req.
  - Required: deny pulse, no grant, gate_open stays 0, count stays 8. A pending exit_req is still granted.
- Timeout:
  - Stimulus: entry_req, car_sense never asserted.
  - Required: gate closes after TIMEOUT_CYCLES, count unchanged; with GATE_STATS_EN, timeouts = 1.
- Re-trigger in HOLD:
  - Stimulus: car_sense toggles high again mid-HOLD.
  - Required: back to PASSING, one commit only, hold restarts after the fall.
- Reset mid-operation:
  - Stimulus: assert reset in PASSING with exit_pend set.
  - Required: immediate gate_open=0, count=0, latches cleared; a later exit_req while empty is dropped.
